// File: rtl/button_event_decoder.sv
// button_event_decoder: turns the debounced button level into SHORT/DOUBLE/LONG events.
// Define BTN_AUTO_REPEAT_EN to emit REPEAT events periodically while a long press is held.
module button_event_decoder #(
    parameter int SYS_FREQ  = 1000,
    parameter int TIME_BASE = 1000,
    parameter int LONG_MS   = 20,
    parameter int DCLICK_MS = 8,
    parameter int REPEAT_MS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       deb,
    input  logic       evt_ack,
    output logic       evt_valid,
    output logic [2:0] evt_code,
    output logic       evt_ovf,
    output logic       held
);
    localparam int DIV  = SYS_FREQ / TIME_BASE;
    localparam int PW   = DIV > 1 ? $clog2(DIV) : 1;
    localparam int M1   = LONG_MS > DCLICK_MS ? LONG_MS : DCLICK_MS;
    localparam int MAXT = M1 > REPEAT_MS ? M1 : REPEAT_MS;
    localparam int TW   = $clog2(MAXT + 1);
    localparam logic [2:0] C_SHORT = 3'd1, C_DOUBLE = 3'd2, C_LONG = 3'd3, C_REPEAT = 3'd4;

    typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG_HELD} state_t;

    state_t          state, nxt;
    logic            deb_d, rise, fall, unit_tick, long_hit, dclk_hit, emit, rpt, restart;
    logic            accept, load, drop;
    logic [2:0]      code;
    logic [PW-1:0]   pre;
    logic [TW-1:0]   timer;

    assign rise      = deb & ~deb_d;
    assign fall      = ~deb & deb_d;
    assign unit_tick = pre == PW'(DIV - 1);
    assign long_hit  = unit_tick && timer == TW'(LONG_MS - 1);
    assign dclk_hit  = unit_tick && timer == TW'(DCLICK_MS - 1);
    assign restart   = (nxt != state) | rpt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    // Edges take priority over a threshold reached in the same cycle, so a release is never lost.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:      nxt = rise ? PRESS1 : IDLE;
            PRESS1:    nxt = fall ? WAIT2 : long_hit ? LONG_HELD : PRESS1;
            WAIT2:     nxt = rise ? PRESS2 : dclk_hit ? IDLE : WAIT2;
            PRESS2:    nxt = fall ? IDLE : PRESS2;
            LONG_HELD: nxt = fall ? IDLE : LONG_HELD;
            default:   nxt = IDLE;
        endcase
    end

`ifdef BTN_AUTO_REPEAT_EN
    logic rpt_hit;
    assign rpt_hit = unit_tick && timer == TW'(REPEAT_MS - 1);
`endif

    always_comb begin
        emit = 1'b0;
        code = 3'd0;
        rpt  = 1'b0;
        held = state == LONG_HELD;
        case (state)
            PRESS1: if (!fall && long_hit) begin
                emit = 1'b1;
                code = C_LONG;
            end
            WAIT2: if (!rise && dclk_hit) begin
                emit = 1'b1;
                code = C_SHORT;
            end
            PRESS2: if (fall) begin
                emit = 1'b1;
                code = C_DOUBLE;
            end
`ifdef BTN_AUTO_REPEAT_EN
            LONG_HELD: if (!fall && rpt_hit) begin
                emit = 1'b1;
                code = C_REPEAT;
                rpt  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // deb_d resets high so a button held through reset needs a fresh press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_d <= 1'b1;
            pre   <= '0;
            timer <= '0;
        end else begin
            deb_d <= deb;
            pre   <= (restart || unit_tick) ? '0 : pre + 1'b1;
            timer <= restart ? '0 : (unit_tick && timer != '1) ? timer + 1'b1 : timer;
        end
    end

    assign accept = evt_valid & evt_ack;
    assign load   = emit & (~evt_valid | evt_ack);
    assign drop   = emit & evt_valid & ~evt_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt_valid <= 1'b0;
            evt_code  <= 3'd0;
            evt_ovf   <= 1'b0;
        end else begin
            evt_valid <= load | (evt_valid & ~evt_ack);
            if (load) evt_code <= code;
            evt_ovf   <= drop | (evt_ovf & ~accept);
        end
    end
endmodule

// File: tb/tb_button_event_decoder.sv
// tb_button_event_decoder: random button activity checked against a phase/elapsed-time
// reference model; expected event codes go through a scoreboard queue.
`timescale 1ns/1ps
module tb_button_event_decoder;
    localparam int DIV = 1000 / 1000, LONG_T = 20, DCLK_T = 8;
`ifdef BTN_AUTO_REPEAT_EN
    localparam int RPT_T = 5;
`endif

    logic       clk = 1'b0, rst = 1'b0, deb = 1'b0, evt_ack = 1'b1;
    logic       evt_valid, evt_ovf, held;
    logic [2:0] evt_code;
    int         checks = 0, errors = 0;
    logic [2:0] expq[$];

    typedef enum {M_IDLE, M_DOWN1, M_GAP, M_DOWN2, M_HOLD} phase_t;
    phase_t     ph = M_IDLE;
    int         el = 0;
    bit         mprev = 1'b1, mvalid = 1'b0, movf = 1'b0;

    button_event_decoder dut (
        .clk(clk), .rst(rst), .deb(deb), .evt_ack(evt_ack),
        .evt_valid(evt_valid), .evt_code(evt_code), .evt_ovf(evt_ovf), .held(held)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: button phases timed by cycles elapsed since the phase began.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph = M_IDLE;
            el = 0;
            mprev = 1'b1;
            mvalid = 1'b0;
            movf = 1'b0;
            expq.delete();
        end else begin : step
            bit rise, fall, emit, rpt;
            bit [2:0] c;
            phase_t np;
            rise = deb && !mprev;
            fall = !deb && mprev;
            emit = 0;
            rpt = 0;
            c = 0;
            np = ph;
            case (ph)
                M_IDLE:  if (rise) np = M_DOWN1;
                M_DOWN1: if (fall) np = M_GAP;
                         else if (el + 1 == LONG_T * DIV) begin emit = 1; c = 3'd3; np = M_HOLD; end
                M_GAP:   if (rise) np = M_DOWN2;
                         else if (el + 1 == DCLK_T * DIV) begin emit = 1; c = 3'd1; np = M_IDLE; end
                M_DOWN2: if (fall) begin emit = 1; c = 3'd2; np = M_IDLE; end
                M_HOLD:  if (fall) np = M_IDLE;
`ifdef BTN_AUTO_REPEAT_EN
                         else if (el + 1 == RPT_T * DIV) begin emit = 1; c = 3'd4; rpt = 1; end
`endif
                default: ;
            endcase
            if (emit && mvalid && !evt_ack) movf = 1;
            else begin
                if (mvalid && evt_ack) begin mvalid = 0; movf = 0; end
                if (emit) begin mvalid = 1; expq.push_back(c); end
            end
            el = (np != ph || rpt) ? 0 : el + 1;
            ph = np;
            mprev = deb;
        end
    end

    // Monitor: flags and valid every cycle; event code popped on each accepted event.
    always @(negedge clk) begin
        if (rst) begin
            chk("evt_valid", evt_valid, mvalid);
            chk("evt_ovf", evt_ovf, movf);
            chk("held", held, ph == M_HOLD);
            if (evt_valid && evt_ack) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got code %0d expected none", evt_code);
                end else chk("evt_code", evt_code, expq.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic seg(input logic lvl, input int n);
        deb = lvl;
        cyc(n);
    endtask

    task automatic seg_rand(input logic lvl, input int n, input bit rand_ack);
        deb = lvl;
        repeat (n) begin
            evt_ack = rand_ack ? logic'($urandom_range(0, 1)) : 1'b1;
            cyc(1);
        end
    endtask

    initial begin
        cyc(2);
        chk("reset_valid", evt_valid, 0);
        chk("reset_code", evt_code, 0);
        chk("reset_ovf", evt_ovf, 0);
        chk("reset_held", held, 0);
        rst = 1'b1;
        cyc(3);
        seg(1, 5); seg(0, 15);
        seg(1, 4); seg(0, 3); seg(1, 4); seg(0, 15);
        seg(1, 30); seg(0, 15);
        // Overflow: SHORT held unacked, LONG dropped.
        evt_ack = 1'b0;
        seg(1, 5); seg(0, 15); seg(1, 30); seg(0, 5);
        chk("ovf_code_kept", evt_code, 1);
        chk("ovf_flag", evt_ovf, 1);
        evt_ack = 1'b1;
        cyc(1);
        evt_ack = 1'b0;
        chk("ack_clears_valid", evt_valid, 0);
        chk("ack_clears_ovf", evt_ovf, 0);
        // Collision: held LONG acked in the cycle a SHORT fires.
        seg(1, 22); seg(0, 5);
        seg(1, 5); seg(0, 8);
        evt_ack = 1'b1;
        cyc(1);
        chk("collide_valid", evt_valid, 1);
        chk("collide_code", evt_code, 1);
        chk("collide_ovf", evt_ovf, 0);
        cyc(3);
        // Reset in the middle of a press; button still down on release.
        seg(1, 10);
        rst = 1'b0;
        #1;
        chk("midrst_valid", evt_valid, 0);
        chk("midrst_code", evt_code, 0);
        chk("midrst_ovf", evt_ovf, 0);
        chk("midrst_held", held, 0);
        cyc(2);
        rst = 1'b1;
        cyc(25);
        chk("held_through_reset", evt_valid | held, 0);
        seg(0, 15);
        chk("release_after_reset", evt_valid, 0);
        seg(1, 5); seg(0, 15);
        repeat (300) seg_rand(~deb, $urandom_range(1, 28), $urandom_range(0, 2) == 0);
        evt_ack = 1'b1;
        seg(0, 40);
        chk("scoreboard_drained", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Consumer of the debouncer's `deb` level; sits directly downstream of the debouncer in the UART/front-panel path.
- Classifies debounced button activity into SHORT, DOUBLE and LONG events using millisecond timing.
- Presents events through a single-entry valid/ack register to the command logic.

Parameters:
- SYS_FREQ, 1000, system clock frequency in Hz.
- TIME_BASE, 1000, timer units per second (1000 = ms). DIV = SYS_FREQ/TIME_BASE cycles per unit; DIV must be >= 1.
- LONG_MS, 20, hold time in units that qualifies a LONG press.
- DCLICK_MS, 8, maximum release gap in units before a second press counts as DOUBLE.
- REPEAT_MS, 5, auto-repeat interval in units (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- deb  in  1  debounced button level from the debouncer; already synchronous to clk.
- evt_ack  in  1  consumer accepts the event; sampled only while evt_valid=1.
- evt_valid  out  1  event register holds an unconsumed event.
- evt_code  out  3  event code: 1=SHORT, 2=DOUBLE, 3=LONG, 4=REPEAT.
- evt_ovf  out  1  sticky flag: an event was dropped because the register was full.
- held  out  1  high while in LONG_HELD.

Behaviour:
- Reset (rst=0, async) clears state to IDLE, timer and prescaler to 0, evt_valid=0, evt_code=0, evt_ovf=0, held=0. The deb_d edge register resets to 1, so a button held through reset is ignored until released and pressed again.
- Edge detect: rise = deb & ~deb_d; fall = ~deb & deb_d; deb_d <= deb every cycle.
- Prescaler:
  - Counts 0..DIV-1 and pulses unit_tick at DIV-1.
  - Prescaler and unit timer clear on every state change, so thresholds are exact.
  - Timer increments on unit_tick and saturates at its max.
  - Threshold T is reached on the cycle where timer==T-1 and unit_tick=1, i.e. T*DIV cycles after state entry.
- FSM transitions are registered; events are emitted on the transition edge.
  - IDLE: rise -> PRESS1. Fall is ignored.
  - PRESS1: fall before LONG_MS -> WAIT2. LONG_MS reached -> emit LONG, go to LONG_HELD.
  - WAIT2: rise before DCLICK_MS -> PRESS2. DCLICK_MS reached -> emit SHORT, go to IDLE.
  - PRESS2: fall -> emit DOUBLE, go to IDLE. There is no long detection in PRESS2.
  - LONG_HELD: held=1. Fall -> IDLE with no event.
- Event register:
  - An emit with evt_valid=0 loads evt_code and sets evt_valid on the same edge, so the event is visible the cycle after the triggering condition.
  - evt_valid & evt_ack clears evt_valid at the next edge.
  - Emit in the same cycle as an accepted ack: the new event is loaded, evt_valid stays 1, no overflow.
  - Emit while evt_valid=1 and evt_ack=0: the new event is dropped, the held event is kept, and evt_ovf is set.
  - evt_ovf clears on the next accepted ack that has no simultaneous overflow.
- evt_ack with evt_valid=0 is ignored.
- Rise and fall in the same cycle is impossible because deb is a single bit.
- Implementation target: 120-250 lines of RTL.

Optional Feature:
- Macro BTN_AUTO_REPEAT_EN.
- Defined: in LONG_HELD, emit REPEAT (code 4) every REPEAT_MS units. The timer restarts after each REPEAT. The first REPEAT comes REPEAT_MS after the LONG event. Overflow rules apply unchanged.
- Undefined: LONG_HELD only waits for release. Code 4 is never produced and REPEAT_MS is unused.

Test Plan (SYS_FREQ=1000, TIME_BASE=1000, so DIV=1; LONG_MS=20, DCLICK_MS=8, REPEAT_MS=5; evt_ack tied to 1 unless stated):
- Short press: deb high 5 cycles, then low -> exactly one evt_valid pulse with code 1, 8 cycles after the fall; held stays 0.
- Double click: high 4, low 3, high 4, then low -> one code-2 event the cycle after the second fall; no code-1 event.
- Long press: deb high 30 cycles -> code 3, 20 cycles after the rise; held=1 from then until the fall; no event on release. With BTN_AUTO_REPEAT_EN: code 4 at +25 and +30 cycles after the rise.
- Overflow: evt_ack=0, short press then long press -> evt_code stays 1 and evt_ovf=1. Then ack=1 for one cycle -> evt_valid=0 and evt_ovf=0 on the next cycle.
- Reset mid-operation: assert rst=0 10 cycles into a press -> all outputs 0 immediately. Release rst with deb still high -> no event until deb falls and rises again.
- Ack/emit collision: a held event is acked on the same cycle a new SHORT fires -> evt_valid stays 1, evt_code=1, evt_ovf=0.
